traffic_phase_controller: RTL and testbench

- Controller on the command side of the saturation countdown timer. It drives the timer's `down` and `loadIn` inputs and consumes its `isZero`.
- Sequences a two-road intersection through green, yellow and all-red phases, loading one duration per phase.
- Holds N/S green while no E/W demand is latched.
- Sits between the timer instance and the lamp drivers in the intersection top level.

---
 rtl/traffic_pkg.sv | 63 ++++++
 rtl/phase_duration_lut.sv | 37 +++
 rtl/traffic_phase_controller.sv | 141 ++++++++++++++
 tb/tb_traffic_phase_controller.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the two-road traffic phase controller.
// Phase encodings are fixed because the phase port drives a top-level display.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    RED_A     = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    RED_B     = 3'd5
  } phase_e;

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  localparam int unsigned DEF_BIT_WIDTH  = 7;
  localparam int unsigned DEF_NS_GREEN_T = 40;
  localparam int unsigned DEF_EW_GREEN_T = 30;
  localparam int unsigned DEF_YELLOW_T   = 5;
  localparam int unsigned DEF_ALL_RED_T  = 2;
  localparam int unsigned DEF_WALK_T     = 10;

  function automatic phase_e next_phase(input phase_e cur);
    phase_e nxt;
    nxt = RED_B;
    case (cur)
      NS_GREEN:  nxt = NS_YELLOW;
      NS_YELLOW: nxt = RED_A;
      RED_A:     nxt = EW_GREEN;
      EW_GREEN:  nxt = EW_YELLOW;
      EW_YELLOW: nxt = RED_B;
      RED_B:     nxt = NS_GREEN;
      default:   nxt = RED_B;
    endcase
    return nxt;
  endfunction

  // Unknown encodings fall back to red so a corrupted state never shows green.
  function automatic logic [2:0] ns_lamp(input phase_e cur);
    logic [2:0] lamp;
    lamp = LAMP_RED;
    case (cur)
      NS_GREEN:  lamp = LAMP_GREEN;
      NS_YELLOW: lamp = LAMP_YELLOW;
      default:   lamp = LAMP_RED;
    endcase
    return lamp;
  endfunction

  function automatic logic [2:0] ew_lamp(input phase_e cur);
    logic [2:0] lamp;
    lamp = LAMP_RED;
    case (cur)
      EW_GREEN:  lamp = LAMP_GREEN;
      EW_YELLOW: lamp = LAMP_YELLOW;
      default:   lamp = LAMP_RED;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/phase_duration_lut.sv
// Combinational phase-to-duration table feeding the timer load value.
// walk_i selects the pedestrian walk duration for RED_B.
module phase_duration_lut
  import traffic_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter int unsigned NS_GREEN_T = DEF_NS_GREEN_T,
  parameter int unsigned EW_GREEN_T = DEF_EW_GREEN_T,
  parameter int unsigned YELLOW_T   = DEF_YELLOW_T,
  parameter int unsigned ALL_RED_T  = DEF_ALL_RED_T,
  parameter int unsigned WALK_T     = DEF_WALK_T
) (
  input  phase_e               state_i,
  input  logic                 walk_i,
  output logic [BIT_WIDTH-1:0] load_o
);

  always_comb begin
    load_o = BIT_WIDTH'(ALL_RED_T);
    case (state_i)
      NS_GREEN:  load_o = BIT_WIDTH'(NS_GREEN_T);
      NS_YELLOW: load_o = BIT_WIDTH'(YELLOW_T);
      RED_A:     load_o = BIT_WIDTH'(ALL_RED_T);
      EW_GREEN:  load_o = BIT_WIDTH'(EW_GREEN_T);
      EW_YELLOW: load_o = BIT_WIDTH'(YELLOW_T);
      RED_B: begin
        if (walk_i) begin
          load_o = BIT_WIDTH'(WALK_T);
        end else begin
          load_o = BIT_WIDTH'(ALL_RED_T);
        end
      end
      default:   load_o = BIT_WIDTH'(ALL_RED_T);
    endcase
  end

endmodule

// File: rtl/traffic_phase_controller.sv
// Two-road phase sequencer driving a load/countdown timer; lamps are registered.
// Optional pedestrian walk phase in RED_B is enabled by TRAFFIC_PED_WALK_EN.
module traffic_phase_controller
  import traffic_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = DEF_BIT_WIDTH,
  parameter int unsigned NS_GREEN_T = DEF_NS_GREEN_T,
  parameter int unsigned EW_GREEN_T = DEF_EW_GREEN_T,
  parameter int unsigned YELLOW_T   = DEF_YELLOW_T,
  parameter int unsigned ALL_RED_T  = DEF_ALL_RED_T,
  parameter int unsigned WALK_T     = DEF_WALK_T
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 timer_zero,
  output logic                 timer_down,
  output logic [BIT_WIDTH-1:0] timer_load,
  input  logic                 ew_sense,
`ifdef TRAFFIC_PED_WALK_EN
  input  logic                 ped_req,
  output logic                 walk,
`endif
  output logic [2:0]           ns_light,
  output logic [2:0]           ew_light,
  output logic [2:0]           phase
);

  phase_e     state_q, state_d;
  logic       loaded_q, loaded_d;
  logic       demand_q, demand_d;
  logic [2:0] ns_q, ns_d;
  logic [2:0] ew_q, ew_d;
  logic       advance_s;
  logic       enter_ew_s;
  logic       lut_walk_s;

`ifdef TRAFFIC_PED_WALK_EN
  logic       ped_q, ped_d;
  logic       walk_q, walk_d;
  logic       enter_red_b_s;
`endif

  // Next-state, handshake flag, demand latch and lamp decode of the next state.
  always_comb begin
    state_d    = state_q;
    loaded_d   = 1'b1;
    // A zero seen during the load cycle belongs to the previous phase.
    advance_s  = loaded_q & timer_zero;
    enter_ew_s = 1'b0;
    if (advance_s) begin
      loaded_d = 1'b0;
      if ((state_q == NS_GREEN) && !(demand_q || ew_sense)) begin
        state_d = NS_GREEN;
      end else begin
        state_d    = next_phase(state_q);
        enter_ew_s = (state_q == RED_A);
      end
    end else begin
      state_d  = state_q;
      loaded_d = 1'b1;
    end

    // Entry into EW_GREEN comes from RED_A, so a same-cycle sense wins.
    if (ew_sense) begin
      demand_d = 1'b1;
    end else if (enter_ew_s) begin
      demand_d = 1'b0;
    end else begin
      demand_d = demand_q;
    end

    ns_d = ns_lamp(state_d);
    ew_d = ew_lamp(state_d);
  end

`ifdef TRAFFIC_PED_WALK_EN
  // Pedestrian latch; the walk flag is captured as RED_B is entered.
  always_comb begin
    enter_red_b_s = advance_s && (state_q == EW_YELLOW);
    if (enter_red_b_s) begin
      ped_d  = 1'b0;
      walk_d = ped_q | ped_req;
    end else if (advance_s) begin
      ped_d  = ped_q | ped_req;
      walk_d = 1'b0;
    end else begin
      ped_d  = ped_q | ped_req;
      walk_d = walk_q;
    end
  end

  assign lut_walk_s = walk_q;
  assign walk       = walk_q;
`else
  assign lut_walk_s = 1'b0;
`endif

  // Phase state register with synchronous active-low reset into RED_B.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= RED_B;
      loaded_q <= 1'b0;
      demand_q <= 1'b0;
      ns_q     <= LAMP_RED;
      ew_q     <= LAMP_RED;
`ifdef TRAFFIC_PED_WALK_EN
      ped_q    <= 1'b0;
      walk_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      loaded_q <= loaded_d;
      demand_q <= demand_d;
      ns_q     <= ns_d;
      ew_q     <= ew_d;
`ifdef TRAFFIC_PED_WALK_EN
      ped_q    <= ped_d;
      walk_q   <= walk_d;
`endif
    end
  end

  phase_duration_lut #(
    .BIT_WIDTH  (BIT_WIDTH),
    .NS_GREEN_T (NS_GREEN_T),
    .EW_GREEN_T (EW_GREEN_T),
    .YELLOW_T   (YELLOW_T),
    .ALL_RED_T  (ALL_RED_T),
    .WALK_T     (WALK_T)
  ) u_lut (
    .state_i (state_q),
    .walk_i  (lut_walk_s),
    .load_o  (timer_load)
  );

  assign timer_down = loaded_q;
  assign ns_light   = ns_q;
  assign ew_light   = ew_q;
  assign phase      = state_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: behavioural timers, phase-segment scoreboard,
// and a second all-zero-duration instance checked every cycle.
module tb_traffic_phase_controller;

  typedef struct {
    logic [2:0] ph;
    int         len;
    logic [6:0] ld;
    logic       wk;
  } seg_t;

  localparam logic [6:0] D_NSG = 7'd40;
  localparam logic [6:0] D_EWG = 7'd30;
  localparam logic [6:0] D_YEL = 7'd5;
  localparam logic [6:0] D_RED = 7'd2;
  localparam logic [6:0] D_WLK = 7'd10;

  logic       clk = 1'b0;
  logic       rst, rst0;
  logic       ew_sense, ew_sense0;
  logic       ped_req, ped_req0;
  logic       timer_zero, timer_down, timer_zero0, timer_down0;
  logic [6:0] timer_load, timer_load0;
  logic [2:0] ns_light, ew_light, phase, ns_light0, ew_light0, phase0;
  logic       walk, walk0;
  logic [6:0] tcnt = 7'd0;
  logic [6:0] tcnt0 = 7'd0;

  int   n_tests = 0;
  int   n_fail = 0;
  seg_t sb[$];
  seg_t cur;
  bit   in_seg = 1'b0;
  bit   mon_en = 1'b0;
  bit   inv_en = 1'b0;
  bit   chk0_en = 1'b0;
  int   idx = 0;
  logic [2:0] m_ph0;
  logic       m_idx0;

  always #5 clk = ~clk;

  traffic_phase_controller dut (
    .clk(clk), .rst(rst), .timer_zero(timer_zero), .timer_down(timer_down),
    .timer_load(timer_load), .ew_sense(ew_sense),
`ifdef TRAFFIC_PED_WALK_EN
    .ped_req(ped_req), .walk(walk),
`endif
    .ns_light(ns_light), .ew_light(ew_light), .phase(phase)
  );

  traffic_phase_controller #(
    .BIT_WIDTH(7), .NS_GREEN_T(0), .EW_GREEN_T(0), .YELLOW_T(0),
    .ALL_RED_T(0), .WALK_T(0)
  ) dut0 (
    .clk(clk), .rst(rst0), .timer_zero(timer_zero0), .timer_down(timer_down0),
    .timer_load(timer_load0), .ew_sense(ew_sense0),
`ifdef TRAFFIC_PED_WALK_EN
    .ped_req(ped_req0), .walk(walk0),
`endif
    .ns_light(ns_light0), .ew_light(ew_light0), .phase(phase0)
  );

  // Behavioural saturating countdown timers
  always @(posedge clk) begin
    if (!timer_down) tcnt <= timer_load;
    else if (tcnt != 7'd0) tcnt <= tcnt - 7'd1;
    if (!timer_down0) tcnt0 <= timer_load0;
    else if (tcnt0 != 7'd0) tcnt0 <= tcnt0 - 7'd1;
  end
  assign timer_zero  = (tcnt == 7'd0);
  assign timer_zero0 = (tcnt0 == 7'd0);

  function automatic logic [2:0] exp_ns(input logic [2:0] p);
    case (p)
      3'd0:    return 3'b001;
      3'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_ew(input logic [2:0] p);
    case (p)
      3'd3:    return 3'b001;
      3'd4:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] ph, input logic [6:0] ld, input logic wk);
    seg_t s;
    s.ph = ph; s.ld = ld; s.len = int'(ld) + 2; s.wk = wk;
    sb.push_back(s);
  endtask

  task automatic inv_check(input string tag, input logic [2:0] ns, input logic [2:0] ew);
    check({tag, "_ns_onehot"}, 32'($onehot(ns)), 32'd1);
    check({tag, "_ew_onehot"}, 32'($onehot(ew)), 32'd1);
    check({tag, "_ew_red_when_ns_green"}, ns[0] ? ew : 3'b100, 3'b100);
    check({tag, "_ns_red_when_ew_green"}, ew[0] ? ns : 3'b100, 3'b100);
  endtask

  // Scoreboard: a phase segment starts whenever timer_down is low
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      in_seg = 1'b0;
    end else if (mon_en) begin
      if (timer_down === 1'b0) begin
        if (in_seg) check("seg_len", idx, cur.len);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          in_seg = 1'b1;
          idx = 0;
        end else begin
          in_seg = 1'b0;
        end
      end
      if (in_seg) begin
        check("phase", phase, cur.ph);
        check("ns_light", ns_light, exp_ns(cur.ph));
        check("ew_light", ew_light, exp_ew(cur.ph));
        check("timer_load", timer_load, cur.ld);
`ifdef TRAFFIC_PED_WALK_EN
        check("walk", walk, cur.wk);
`endif
        idx++;
      end
    end
  end

  // Invariants on both instances and the two-cycle model of the zero-duration one
  always @(negedge clk) begin
    if (inv_en) begin
      inv_check("main", ns_light, ew_light);
      inv_check("zero", ns_light0, ew_light0);
    end
    if (chk0_en) begin
      check("z_phase", phase0, m_ph0);
      check("z_down", timer_down0, m_idx0);
      check("z_load", timer_load0, 7'd0);
      check("z_ns", ns_light0, exp_ns(m_ph0));
      check("z_ew", ew_light0, exp_ew(m_ph0));
      if (m_idx0) m_ph0 = (m_ph0 == 3'd5) ? 3'd0 : m_ph0 + 3'd1;
      m_idx0 = ~m_idx0;
    end
  end

  task automatic reset_checks();
    @(negedge clk);
    check("rst_phase", phase, 3'd5);
    check("rst_ns", ns_light, 3'b100);
    check("rst_ew", ew_light, 3'b100);
    check("rst_down", timer_down, 1'b0);
    check("rst_load", timer_load, 7'd2);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    reset_checks();
  endtask

  task automatic pulse_ew_at(input int cyc);
    repeat (cyc) @(posedge clk);
    #2 ew_sense = 1'b1;
    @(posedge clk);
    #2 ew_sense = 1'b0;
  endtask

  task automatic wait_drained(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || in_seg) && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 32'(sb.size() == 0 && !in_seg), 32'd1);
    #2;
  endtask

  initial begin
    rst = 1'b0; rst0 = 1'b0; ew_sense = 1'b1; ew_sense0 = 1'b1;
    ped_req = 1'b0; ped_req0 = 1'b0;
    @(posedge clk); #2;

    // Full cycle with E/W demand held
    push(3'd5, D_RED, 1'b0); push(3'd0, D_NSG, 1'b0); push(3'd1, D_YEL, 1'b0);
    push(3'd2, D_RED, 1'b0); push(3'd3, D_EWG, 1'b0); push(3'd4, D_YEL, 1'b0);
    mon_en = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1; rst0 = 1'b1;
    m_ph0 = 3'd5; m_idx0 = 1'b0; chk0_en = 1'b1; inv_en = 1'b1;
    reset_checks();
    wait_drained(400);

    // No demand: N/S green re-enters, then a one-cycle pulse mid-green
    ew_sense = 1'b0;
    push(3'd5, D_RED, 1'b0); push(3'd0, D_NSG, 1'b0); push(3'd0, D_NSG, 1'b0);
    push(3'd1, D_YEL, 1'b0); push(3'd2, D_RED, 1'b0);
    do_reset();
    pulse_ew_at(56);
    wait_drained(400);

    // Reset mid-EW_GREEN, then a pulse only in the N/S green expiry cycle
    repeat (5) @(posedge clk);
    #2;
    push(3'd5, D_RED, 1'b0); push(3'd0, D_NSG, 1'b0); push(3'd1, D_YEL, 1'b0);
    push(3'd2, D_RED, 1'b0);
    do_reset();
    pulse_ew_at(45);
    wait_drained(400);

`ifdef TRAFFIC_PED_WALK_EN
    // Pedestrian request stretches exactly one RED_B into a walk phase
    ew_sense = 1'b1;
    push(3'd5, D_RED, 1'b0); push(3'd0, D_NSG, 1'b0); push(3'd1, D_YEL, 1'b0);
    push(3'd2, D_RED, 1'b0); push(3'd3, D_EWG, 1'b0); push(3'd4, D_YEL, 1'b0);
    push(3'd5, D_WLK, 1'b1); push(3'd0, D_NSG, 1'b0); push(3'd1, D_YEL, 1'b0);
    push(3'd2, D_RED, 1'b0); push(3'd3, D_EWG, 1'b0); push(3'd4, D_YEL, 1'b0);
    push(3'd5, D_RED, 1'b0);
    do_reset();
    repeat (10) @(posedge clk);
    #2 ped_req = 1'b1;
    @(posedge clk);
    #2 ped_req = 1'b0;
    wait_drained(800);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
